// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a PC-indexed table of 2-bit saturating counters read in
// Fetch, with misprediction detection, training and saturating statistics in Execute.
module branch_predictor #(
    parameter int INDEX_WIDTH = 6,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [31:0]          pc_f_i,
    output logic                 pred_taken_f_o,
    input  logic [31:0]          pc_e_i,
    input  logic [1:0]           branch_op_e_i,
    input  logic                 pred_taken_e_i,
    input  logic                 pc_src_res_e_i,
    input  logic                 stall_e_i,
    input  logic                 flush_e_i,
    output logic                 mispredict_e_o,
    output logic [CNT_WIDTH-1:0] branch_count_o,
    output logic [CNT_WIDTH-1:0] mispredict_count_o
);
    // Branch classes: 00 non-branch, 01 conditional branch, 10 jump; 11 acts as non-branch.
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam int         DEPTH     = 1 << INDEX_WIDTH;

    logic [1:0]             table_q [DEPTH];
    logic [INDEX_WIDTH-1:0] index_f;
    logic [INDEX_WIDTH-1:0] index_e;
    logic [1:0]             entry_e;
    logic [1:0]             entry_next;
    logic                   valid_e;
    logic                   train;
    logic [CNT_WIDTH-1:0]   branch_count_q;
    logic [CNT_WIDTH-1:0]   mispredict_count_q;
    logic                   unused_pc_bits;

    assign index_f = pc_f_i[INDEX_WIDTH+1:2];
    assign index_e = pc_e_i[INDEX_WIDTH+1:2];
    assign unused_pc_bits = ^{pc_f_i[31:INDEX_WIDTH+2], pc_f_i[1:0],
                              pc_e_i[31:INDEX_WIDTH+2], pc_e_i[1:0]};

    // The read sees the registered table, so a same-index update shows up next cycle.
    assign pred_taken_f_o = table_q[index_f][1];

    // A stalled instruction repeats, so only the unstalled copy trains or counts.
    assign valid_e        = ~stall_e_i & ~flush_e_i;
    assign mispredict_e_o = valid_e & (pred_taken_e_i != pc_src_res_e_i);
    assign train          = valid_e & (branch_op_e_i == OP_BRANCH);
    assign entry_e        = table_q[index_e];

    always_comb begin
        entry_next = entry_e;
        if (pc_src_res_e_i) begin
            if (entry_e != 2'b11) entry_next = entry_e + 2'd1;
        end else begin
            if (entry_e != 2'b00) entry_next = entry_e - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= 2'b01;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (train) table_q[index_e] <= entry_next;
            if (train && (branch_count_q != '1))
                branch_count_q <= branch_count_q + CNT_WIDTH'(1);
            if (mispredict_e_o && (mispredict_count_q != '1))
                mispredict_count_q <= mispredict_count_q + CNT_WIDTH'(1);
        end
    end

    assign branch_count_o     = branch_count_q;
    assign mispredict_count_o = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed scenarios plus randomized traffic checked
// against a table-of-integers reference model.
module tb_branch_predictor;
    localparam int IW = 8;
    localparam int CW = 32;
    localparam logic [1:0] OP_NON    = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_JUMP   = 2'b10;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic [31:0]   pc_f_i;
    logic          pred_taken_f_o;
    logic [31:0]   pc_e_i;
    logic [1:0]    branch_op_e_i;
    logic          pred_taken_e_i;
    logic          pc_src_res_e_i;
    logic          stall_e_i;
    logic          flush_e_i;
    logic          mispredict_e_o;
    logic [CW-1:0] branch_count_o;
    logic [CW-1:0] mispredict_count_o;

    int vectors = 0;
    int errors  = 0;

    // Reference model: each entry is an integer confidence 0..3; taken when >= 2.
    int            model_tab [1 << IW];
    logic [CW-1:0] model_bc;
    logic [CW-1:0] model_mc;

    branch_predictor #(.INDEX_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .clk_i              (clk_i),
        .reset_n_i          (reset_n_i),
        .pc_f_i             (pc_f_i),
        .pred_taken_f_o     (pred_taken_f_o),
        .pc_e_i             (pc_e_i),
        .branch_op_e_i      (branch_op_e_i),
        .pred_taken_e_i     (pred_taken_e_i),
        .pc_src_res_e_i     (pc_src_res_e_i),
        .stall_e_i          (stall_e_i),
        .flush_e_i          (flush_e_i),
        .mispredict_e_o     (mispredict_e_o),
        .branch_count_o     (branch_count_o),
        .mispredict_count_o (mispredict_count_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) & ((1 << IW) - 1));
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = ($urandom_range(0, 3) << (IW + 2)) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < (1 << IW); i++) model_tab[i] = 1;
        model_bc = '0;
        model_mc = '0;
    endtask

    task automatic drive(input logic [31:0] pf, input logic [31:0] pe, input logic [1:0] op,
                         input logic pt, input logic res, input logic st, input logic fl);
        pc_f_i         = pf;
        pc_e_i         = pe;
        branch_op_e_i  = op;
        pred_taken_e_i = pt;
        pc_src_res_e_i = res;
        stall_e_i      = st;
        flush_e_i      = fl;
    endtask

    task automatic drive_idle(input logic [31:0] pf);
        drive(pf, 32'h0, OP_NON, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Advance one clock; the model consumes the same inputs the DUT samples on that edge.
    task automatic tick();
        bit v;
        int i;
        @(posedge clk_i);
        v = !stall_e_i && !flush_e_i;
        if (v && branch_op_e_i == OP_BRANCH) begin
            i = idx(pc_e_i);
            if (pc_src_res_e_i) model_tab[i] = (model_tab[i] >= 3) ? 3 : model_tab[i] + 1;
            else                model_tab[i] = (model_tab[i] <= 0) ? 0 : model_tab[i] - 1;
            if (model_bc != '1) model_bc = model_bc + 1;
        end
        if (v && (pred_taken_e_i != pc_src_res_e_i) && model_mc != '1) model_mc = model_mc + 1;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] p;
        reset_n_i = 1'b0;
        drive_idle(32'h100);
        model_reset();
        #12;
        vectors++;
        if (pred_taken_f_o !== 1'b0) begin
            errors++; $display("FAIL reset_pred: got %b expected 0", pred_taken_f_o);
        end
        vectors++;
        if (branch_count_o !== '0) begin
            errors++; $display("FAIL reset_bc: got %0d expected 0", branch_count_o);
        end
        vectors++;
        if (mispredict_count_o !== '0) begin
            errors++; $display("FAIL reset_mc: got %0d expected 0", mispredict_count_o);
        end
        reset_n_i = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            p = $urandom;
            drive_idle(p);
            #1;
            vectors++;
            if (pred_taken_f_o !== 1'b0) begin
                errors++; $display("FAIL reset_pred_any pc=%h: got %b expected 0", p, pred_taken_f_o);
            end
        end
        tick();
    endtask

    task automatic test_train_taken();
        for (int k = 1; k <= 3; k++) begin
            drive(32'h100, 32'h100, OP_BRANCH, 1'b1, 1'b1, 1'b0, 1'b0);
            #1;
            vectors++;
            if (pred_taken_f_o !== (k > 1)) begin
                errors++; $display("FAIL train_pred_pre[%0d]: got %b expected %b", k, pred_taken_f_o, (k > 1));
            end
            vectors++;
            if (mispredict_e_o !== 1'b0) begin
                errors++; $display("FAIL train_mis[%0d]: got %b expected 0", k, mispredict_e_o);
            end
            tick();
            vectors++;
            if (pred_taken_f_o !== 1'b1) begin
                errors++; $display("FAIL train_pred_post[%0d]: got %b expected 1", k, pred_taken_f_o);
            end
            vectors++;
            if (branch_count_o !== CW'(k)) begin
                errors++; $display("FAIL train_bc[%0d]: got %0d expected %0d", k, branch_count_o, k);
            end
        end
    endtask

    task automatic test_stall_mispredict();
        drive(32'h100, 32'h100, OP_BRANCH, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            #1;
            vectors++;
            if (mispredict_e_o !== 1'b0) begin
                errors++; $display("FAIL stall_mis[%0d]: got %b expected 0", k, mispredict_e_o);
            end
            tick();
        end
        stall_e_i = 1'b0;
        #1;
        vectors++;
        if (mispredict_e_o !== 1'b1) begin
            errors++; $display("FAIL stall_release_mis: got %b expected 1", mispredict_e_o);
        end
        tick();
        drive_idle(32'h100);
        #1;
        vectors++;
        if (mispredict_e_o !== 1'b0) begin
            errors++; $display("FAIL stall_after_mis: got %b expected 0", mispredict_e_o);
        end
        // A single decrement from 11 leaves 10, still predicting taken.
        vectors++;
        if (pred_taken_f_o !== 1'b1) begin
            errors++; $display("FAIL stall_single_update: got %b expected 1", pred_taken_f_o);
        end
        vectors++;
        if (mispredict_count_o !== CW'(1)) begin
            errors++; $display("FAIL stall_mc: got %0d expected 1", mispredict_count_o);
        end
        vectors++;
        if (branch_count_o !== CW'(4)) begin
            errors++; $display("FAIL stall_bc: got %0d expected 4", branch_count_o);
        end
    endtask

    task automatic test_jump();
        drive(32'h200, 32'h200, OP_JUMP, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        vectors++;
        if (mispredict_e_o !== 1'b1) begin
            errors++; $display("FAIL jump_mis: got %b expected 1", mispredict_e_o);
        end
        tick();
        drive_idle(32'h200);
        #1;
        vectors++;
        if (pred_taken_f_o !== 1'b0) begin
            errors++; $display("FAIL jump_no_train: got %b expected 0", pred_taken_f_o);
        end
        vectors++;
        if (branch_count_o !== CW'(4)) begin
            errors++; $display("FAIL jump_bc: got %0d expected 4", branch_count_o);
        end
        vectors++;
        if (mispredict_count_o !== CW'(2)) begin
            errors++; $display("FAIL jump_mc: got %0d expected 2", mispredict_count_o);
        end
    endtask

    task automatic test_collision_flush();
        drive(32'h300, 32'h300, OP_BRANCH, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        vectors++;
        if (pred_taken_f_o !== 1'b0) begin
            errors++; $display("FAIL collide_pre: got %b expected 0", pred_taken_f_o);
        end
        tick();
        drive(32'h300, 32'h300, OP_BRANCH, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        vectors++;
        if (pred_taken_f_o !== 1'b1) begin
            errors++; $display("FAIL collide_post: got %b expected 1", pred_taken_f_o);
        end
        vectors++;
        if (mispredict_e_o !== 1'b0) begin
            errors++; $display("FAIL flush_mis: got %b expected 0", mispredict_e_o);
        end
        tick();
        drive_idle(32'h300);
        #1;
        vectors++;
        if (pred_taken_f_o !== 1'b1) begin
            errors++; $display("FAIL flush_no_train: got %b expected 1", pred_taken_f_o);
        end
        vectors++;
        if (branch_count_o !== CW'(5)) begin
            errors++; $display("FAIL flush_bc: got %0d expected 5", branch_count_o);
        end
        vectors++;
        if (mispredict_count_o !== CW'(2)) begin
            errors++; $display("FAIL flush_mc: got %0d expected 2", mispredict_count_o);
        end
    endtask

    task automatic test_random();
        logic [31:0] pf, pe;
        logic [1:0]  op;
        logic        pt, res, st, fl, exp_pred, exp_mis;
        for (int n = 0; n < 400; n++) begin
            pe  = rand_pc();
            pf  = ($urandom_range(0, 3) == 0) ? pe : rand_pc();
            op  = 2'($urandom_range(0, 3));
            res = (op == OP_BRANCH) ? 1'($urandom_range(0, 1)) : (op == OP_JUMP);
            pt  = 1'($urandom_range(0, 1));
            st  = ($urandom_range(0, 7) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            drive(pf, pe, op, pt, res, st, fl);
            #1;
            exp_pred = (model_tab[idx(pf)] >= 2);
            exp_mis  = !st && !fl && (pt != res);
            vectors++;
            if (pred_taken_f_o !== exp_pred) begin
                errors++; $display("FAIL rand_pred[%0d] pc=%h: got %b expected %b", n, pf, pred_taken_f_o, exp_pred);
            end
            vectors++;
            if (mispredict_e_o !== exp_mis) begin
                errors++; $display("FAIL rand_mis[%0d]: got %b expected %b", n, mispredict_e_o, exp_mis);
            end
            tick();
            vectors++;
            if (branch_count_o !== model_bc) begin
                errors++; $display("FAIL rand_bc[%0d]: got %0d expected %0d", n, branch_count_o, model_bc);
            end
            vectors++;
            if (mispredict_count_o !== model_mc) begin
                errors++; $display("FAIL rand_mc[%0d]: got %0d expected %0d", n, mispredict_count_o, model_mc);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] p;
        drive_idle(32'h300);
        #1;
        vectors++;
        if (pred_taken_f_o !== 1'b1) begin
            errors++; $display("FAIL areset_before: got %b expected 1", pred_taken_f_o);
        end
        #2;
        reset_n_i = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (pred_taken_f_o !== 1'b0) begin
            errors++; $display("FAIL areset_pred: got %b expected 0", pred_taken_f_o);
        end
        vectors++;
        if (branch_count_o !== '0) begin
            errors++; $display("FAIL areset_bc: got %0d expected 0", branch_count_o);
        end
        vectors++;
        if (mispredict_count_o !== '0) begin
            errors++; $display("FAIL areset_mc: got %0d expected 0", mispredict_count_o);
        end
        for (int k = 0; k < 8; k++) begin
            p = rand_pc();
            pc_f_i = p;
            #1;
            vectors++;
            if (pred_taken_f_o !== 1'b0) begin
                errors++; $display("FAIL areset_pred_any pc=%h: got %b expected 0", p, pred_taken_f_o);
            end
        end
        @(negedge clk_i);
        reset_n_i = 1'b1;
        tick();
        drive(32'h100, 32'h100, OP_BRANCH, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive_idle(32'h100);
        #1;
        vectors++;
        if (pred_taken_f_o !== 1'b1) begin
            errors++; $display("FAIL areset_retrain: got %b expected 1", pred_taken_f_o);
        end
        vectors++;
        if (mispredict_count_o !== CW'(1)) begin
            errors++; $display("FAIL areset_retrain_mc: got %0d expected 1", mispredict_count_o);
        end
    endtask

    initial begin
        test_reset();
        test_train_taken();
        test_stall_mispredict();
        test_jump();
        test_collision_flush();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor and misprediction controller for the pipelined RISC-V core.
- In Fetch, gives a taken/not-taken prediction from a PC-indexed table of 2-bit saturating counters.
- In Execute, compares the prediction carried down the pipeline against the resolved outcome. It raises a flush/redirect request on mismatch and trains the table.
- Also keeps saturating performance counters for executed branches and mispredictions.

Parameters:
- INDEX_WIDTH, 6, log2 of table depth; table has 2^INDEX_WIDTH entries, indexed by PC[INDEX_WIDTH+1:2].
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- clk_i  input  1  core clock; all state updates on rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- pc_f_i  input  32  Fetch-stage PC.
- pred_taken_f_o  output  1  Fetch prediction; MSB of the indexed counter.
- pc_e_i  input  32  Execute-stage PC of the instruction being resolved.
- branch_op_e_i  input  2  Execute branch class; NON_BRANCH, BRANCH or JUMP per control_macros.
- pred_taken_e_i  input  1  prediction issued for this instruction, carried Fetch→Execute.
- pc_src_res_e_i  input  1  resolved outcome from the resolution logic; 1 = taken.
- stall_e_i  input  1  Execute is stalled; the instruction repeats next cycle.
- flush_e_i  input  1  Execute holds a bubble or a squashed instruction.
- mispredict_e_o  output  1  redirect/flush request to hazard unit and PC mux.
- branch_count_o  output  CNT_WIDTH  retired conditional branches.
- mispredict_count_o  output  CNT_WIDTH  mispredictions signalled.

Behaviour:
- Reset:
  - Asynchronous on reset_n_i low.
  - Every table entry is set to 2'b01 (weakly not-taken).
  - Both counters are cleared to 0.
  - A reset mid-operation discards all training immediately.
- Counter encoding: 00 strongly NT, 01 weakly NT, 10 weakly T, 11 strongly T. Prediction = bit[1].
- Fetch read:
  - Combinational from pc_f_i.
  - After reset, pred_taken_f_o = 0 for every PC.
- valid_e = ~stall_e_i & ~flush_e_i. Stalled cycles never train or count, so there is no double update.
- mispredict_e_o:
  - Combinational: valid_e & (pred_taken_e_i != pc_src_res_e_i).
  - NON_BRANCH has pc_src_res_e_i = 0, so a NON_BRANCH predicted taken asserts mispredict.
  - A JUMP predicted not-taken asserts mispredict.
  - Zero latency: asserted in the same cycle as the Execute inputs.
- Training:
  - Occurs on the clock edge only when valid_e and branch_op_e_i == BRANCH.
  - Entry at index pc_e_i[INDEX_WIDTH+1:2] is incremented if pc_src_res_e_i = 1, decremented if 0.
  - Saturates at 11 and 00 (no wrap).
  - JUMP and NON_BRANCH never train.
- Same-cycle read/write collision (Fetch index equals Execute index):
  - pred_taken_f_o reflects the pre-update value.
  - The new value is visible from the next cycle.
- Aliasing: PCs sharing index bits share an entry. There are no tags; this is intended.
- branch_count_o increments on each valid_e BRANCH.
- mispredict_count_o increments on each cycle mispredict_e_o = 1.
- Both counters saturate at all-ones and hold; they never wrap.
- Unknown branch_op_e_i encodings are treated as NON_BRANCH.

Test Plan:
1. Reset, then pc_f_i = 0x100 → pred_taken_f_o = 0. Both counters = 0.
2. Three valid BRANCHes at pc_e_i = 0x100, resolved taken with matching pred_taken_e_i → entry goes 01→10→11→11. pc_f_i = 0x100 predicts 1 from the cycle after the first update. branch_count_o = 3.
3. BRANCH at 0x100 with pred_taken_e_i = 1 and pc_src_res_e_i = 0, stall_e_i = 1 for 2 cycles then 0:
   - mispredict_e_o is 0 while stalled, then 1 for one cycle.
   - The entry decrements exactly once (11→10).
   - mispredict_count_o = 1.
4. JUMP at 0x200 with pred_taken_e_i = 0 → mispredict_e_o = 1. Entry for 0x200 stays 01. branch_count_o unchanged.
5. pc_f_i = pc_e_i = 0x300, taken BRANCH training 01→10 → pred_taken_f_o = 0 in that cycle, 1 next cycle. Also: flush_e_i = 1 with mismatched prediction → no mispredict, no update.
6. Drive reset_n_i low asynchronously mid-sequence, away from any clock edge → all predictions return to 0 and counters read 0 immediately.
